// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types: op encodings, operand select, control word, latency limits
package alu_pkg;

    // Legal pipeline depth range for pipelined_alu.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    // 5-bit encoding leaves room for unknown opcodes, which evaluate to a zero result.
    typedef enum logic [4:0] {
        add_op                = 5'd0,
        sub_op                = 5'd1,
        xor_op                = 5'd2,
        or_op                 = 5'd3,
        and_op                = 5'd4,
        sll_op                = 5'd5,
        srl_op                = 5'd6,
        sra_op                = 5'd7,
        slt_op                = 5'd8,
        sltu_op               = 5'd9,
        eq_op                 = 5'd10,
        not_eq_op             = 5'd11,
        less_than_op          = 5'd12,
        greater_equal_than_op = 5'd13,
        ltu_op                = 5'd14,
        geu_op                = 5'd15
    } alu_op_t;

    typedef enum logic {
        src_reg2 = 1'b0,
        src_imm  = 1'b1
    } alu_src_t;

    typedef struct packed {
        alu_op_t  alu_op;
        alu_src_t alu_src;
        logic     is_branch_op;
    } control_t;

endpackage

// File: rtl/pipelined_alu_exec.sv
// rtl/pipelined_alu_exec.sv - combinational ALU/branch evaluation feeding the first pipeline stage
//
// Ports:
//   src1_val, src2_val, immediate : operands (immediate already sign-extended to DATA_WIDTH)
//   control                       : alu_op, alu_src, is_branch_op
//   pc_in                         : instruction PC
//   result                        : ALU result (0 for branches and unknown ops)
//   is_br, taken, target          : branch flag, outcome and next PC
module alu_exec_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 32
) (
    input  logic [DATA_WIDTH-1:0] src1_val,
    input  logic [DATA_WIDTH-1:0] src2_val,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  control_t              control,
    input  logic [ADDR_W-1:0]     pc_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  is_br,
    output logic                  taken,
    output logic [ADDR_W-1:0]     target
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] op2;
    logic [SHW-1:0]        shamt;
    logic [ADDR_W-1:0]     imm_ext;

    assign op2   = (control.alu_src == src_reg2) ? src2_val : immediate;
    assign shamt = op2[SHW-1:0];
    // Signed cast so the offset keeps its sign if ADDR_W is wider than DATA_WIDTH.
    assign imm_ext = ADDR_W'($signed(immediate));

    always_comb begin
        result = '0;
        is_br  = 1'b0;
        taken  = 1'b0;
        target = '0;
        if (control.is_branch_op) begin
            // Branch compares always use the register operand, never the immediate.
            is_br = 1'b1;
            case (control.alu_op)
                eq_op:                 taken = (src1_val == src2_val);
                not_eq_op:             taken = (src1_val != src2_val);
                less_than_op:          taken = ($signed(src1_val) <  $signed(src2_val));
                greater_equal_than_op: taken = ($signed(src1_val) >= $signed(src2_val));
                ltu_op:                taken = (src1_val <  src2_val);
                geu_op:                taken = (src1_val >= src2_val);
                default:               is_br = 1'b0;
            endcase
            if (is_br) begin
                target = taken ? (pc_in + (imm_ext << 1)) : (pc_in + ADDR_W'(4));
            end
        end else begin
            case (control.alu_op)
                add_op:  result = src1_val + op2;
                sub_op:  result = src1_val - op2;
                xor_op:  result = src1_val ^ op2;
                or_op:   result = src1_val | op2;
                and_op:  result = src1_val & op2;
                sll_op:  result = src1_val << shamt;
                srl_op:  result = src1_val >> shamt;
                sra_op:  result = $signed(src1_val) >>> shamt;
                slt_op:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src1_val) < $signed(op2))};
                sltu_op: result = {{(DATA_WIDTH-1){1'b0}}, (src1_val < op2)};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - LATENCY-deep ALU pipeline with CDB backpressure, branch resolution and flush
//
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready                       : issue handshake from the reservation station
//   src1_val, src2_val, immediate, control  : operands and decoded control
//   dst_reg_addr, pc_in, tag_in             : destination, PC and ROB tag of the issued op
//   flush                                   : kill everything in flight (including this cycle's issue)
//   out_valid/out_ready, result_val, result_addr, tag_out : result to CDB/ROB
//   br_valid, br_taken, br_target           : one-cycle branch resolution pulse
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_W     = 6,
    parameter int TAG_W      = 5,
    parameter int ADDR_W     = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] src1_val,
    input  logic [DATA_WIDTH-1:0] src2_val,
    input  logic [DATA_WIDTH-1:0] immediate,
    input  control_t              control,
    input  logic [PREG_W-1:0]     dst_reg_addr,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result_val,
    output logic [PREG_W-1:0]     result_addr,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  br_valid,
    output logic                  br_taken,
    output logic [ADDR_W-1:0]     br_target
);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_range_check
        $error("pipelined_alu: LATENCY out of range");
    end

    localparam int LAST = LATENCY - 1;

    logic [DATA_WIDTH-1:0] ex_result;
    logic                  ex_is_br;
    logic                  ex_taken;
    logic [ADDR_W-1:0]     ex_target;

    // Stage 0 here is S1, stage LAST is the output stage.
    logic [LATENCY-1:0]                 st_valid;
    logic [LATENCY-1:0]                 st_is_br;
    logic [LATENCY-1:0]                 st_taken;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] st_result;
    logic [LATENCY-1:0][PREG_W-1:0]     st_addr;
    logic [LATENCY-1:0][TAG_W-1:0]      st_tag;
    logic [LATENCY-1:0][ADDR_W-1:0]     st_target;

    logic stall;
    logic accept;

    alu_exec_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_exec (
        .src1_val  (src1_val),
        .src2_val  (src2_val),
        .immediate (immediate),
        .control   (control),
        .pc_in     (pc_in),
        .result    (ex_result),
        .is_br     (ex_is_br),
        .taken     (ex_taken),
        .target    (ex_target)
    );

    // Only a non-branch result waiting on the CDB can stall; branch pulses never wait.
    assign stall    = st_valid[LAST] && !st_is_br[LAST] && !out_ready;
    assign in_ready = reset && !stall;
    assign accept   = in_valid && in_ready;

    assign out_valid   = reset && st_valid[LAST] && !st_is_br[LAST];
    assign br_valid    = reset && st_valid[LAST] &&  st_is_br[LAST];
    assign result_val  = st_result[LAST];
    assign result_addr = st_addr[LAST];
    assign tag_out     = st_tag[LAST];
    assign br_taken    = st_taken[LAST];
    assign br_target   = st_target[LAST];

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_valid  <= '0;
            st_is_br  <= '0;
            st_taken  <= '0;
            st_result <= '0;
            st_addr   <= '0;
            st_tag    <= '0;
            st_target <= '0;
        end else if (flush) begin
            st_valid <= '0;
        end else if (!stall) begin
            // Bubbles carry a zero payload so idle outputs stay quiet.
            st_valid[0]  <= accept;
            st_is_br[0]  <= accept ? ex_is_br     : 1'b0;
            st_taken[0]  <= accept ? ex_taken     : 1'b0;
            st_result[0] <= accept ? ex_result    : '0;
            st_addr[0]   <= accept ? dst_reg_addr : '0;
            st_tag[0]    <= accept ? tag_in       : '0;
            st_target[0] <= accept ? ex_target    : '0;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i]  <= st_valid[i-1];
                st_is_br[i]  <= st_is_br[i-1];
                st_taken[i]  <= st_taken[i-1];
                st_result[i] <= st_result[i-1];
                st_addr[i]   <= st_addr[i-1];
                st_tag[i]    <= st_tag[i-1];
                st_target[i] <= st_target[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - directed table-driven bench for pipelined_alu (LATENCY=2)
module tb_pipelined_alu;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int TW = 5;
    localparam int AW = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] src1_val, src2_val, immediate;
    control_t      control;
    logic [PW-1:0] dst_reg_addr;
    logic [AW-1:0] pc_in;
    logic [TW-1:0] tag_in;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result_val;
    logic [PW-1:0] result_addr;
    logic [TW-1:0] tag_out;
    logic          br_valid, br_taken;
    logic [AW-1:0] br_target;

    pipelined_alu #(
        .DATA_WIDTH (DW), .PREG_W (PW), .TAG_W (TW), .ADDR_W (AW), .LATENCY (LAT)
    ) dut (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
        .src1_val (src1_val), .src2_val (src2_val), .immediate (immediate),
        .control (control), .dst_reg_addr (dst_reg_addr), .pc_in (pc_in),
        .tag_in (tag_in), .flush (flush), .out_valid (out_valid),
        .out_ready (out_ready), .result_val (result_val), .result_addr (result_addr),
        .tag_out (tag_out), .br_valid (br_valid), .br_taken (br_taken),
        .br_target (br_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_op_t  op;
        alu_src_t src;
        logic     br;
        logic [DW-1:0] s1, s2, imm;
        logic [AW-1:0] pc;
        logic [DW-1:0] exp_res;
        logic          exp_br;
        logic          exp_taken;
        logic [AW-1:0] exp_tgt;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(alu_op_t op, alu_src_t src, logic br,
                                logic [DW-1:0] s1, logic [DW-1:0] s2, logic [DW-1:0] imm,
                                logic [AW-1:0] pc, logic [DW-1:0] r, logic eb, logic et,
                                logic [AW-1:0] tg);
        vec_t v;
        v.op = op; v.src = src; v.br = br; v.s1 = s1; v.s2 = s2; v.imm = imm; v.pc = pc;
        v.exp_res = r; v.exp_br = eb; v.exp_taken = et; v.exp_tgt = tg;
        return v;
    endfunction

    // Drives vector i with destination i+12 and tag i+3.
    task automatic drive(input int i);
        in_valid          = 1'b1;
        control.alu_op    = vecs[i].op;
        control.alu_src   = vecs[i].src;
        control.is_branch_op = vecs[i].br;
        src1_val          = vecs[i].s1;
        src2_val          = vecs[i].s2;
        immediate         = vecs[i].imm;
        pc_in             = vecs[i].pc;
        dst_reg_addr      = PW'(i + 12);
        tag_in            = TW'(i + 3);
    endtask

    task automatic check_out(input int i, input string pfx);
        if (vecs[i].exp_br) begin
            check($sformatf("%s%0d_br_valid", pfx, i), 64'(br_valid), 64'd1);
            check($sformatf("%s%0d_out_valid", pfx, i), 64'(out_valid), 64'd0);
            check($sformatf("%s%0d_taken", pfx, i), 64'(br_taken), 64'(vecs[i].exp_taken));
            check($sformatf("%s%0d_target", pfx, i), 64'(br_target), 64'(vecs[i].exp_tgt));
            check($sformatf("%s%0d_result", pfx, i), 64'(result_val), 64'd0);
        end else begin
            check($sformatf("%s%0d_out_valid", pfx, i), 64'(out_valid), 64'd1);
            check($sformatf("%s%0d_br_valid", pfx, i), 64'(br_valid), 64'd0);
            check($sformatf("%s%0d_result", pfx, i), 64'(result_val), 64'(vecs[i].exp_res));
            check($sformatf("%s%0d_addr", pfx, i), 64'(result_addr), 64'(i + 12));
        end
        check($sformatf("%s%0d_tag", pfx, i), 64'(tag_out), 64'(i + 3));
    endtask

    initial begin
        //              op                     src       br  s1            s2            imm           pc        result        br taken target
        vecs[0]  = mk(add_op,                src_reg2, 0, 32'd5,        32'd7,        32'd0,        32'h0,    32'd12,       0, 0, 32'h0);
        vecs[1]  = mk(sub_op,                src_reg2, 0, 32'd10,       32'd3,        32'd0,        32'h0,    32'd7,        0, 0, 32'h0);
        vecs[2]  = mk(sra_op,                src_imm,  0, 32'h80000000, 32'd0,        32'd4,        32'h0,    32'hF8000000, 0, 0, 32'h0);
        vecs[3]  = mk(slt_op,                src_reg2, 0, 32'hFFFFFFFF, 32'd5,        32'd0,        32'h0,    32'd1,        0, 0, 32'h0);
        vecs[4]  = mk(sltu_op,               src_reg2, 0, 32'hFFFFFFFF, 32'd5,        32'd0,        32'h0,    32'd0,        0, 0, 32'h0);
        vecs[5]  = mk(xor_op,                src_reg2, 0, 32'h0000F0F0, 32'h00000FF0, 32'd0,        32'h0,    32'h0000FF00, 0, 0, 32'h0);
        vecs[6]  = mk(or_op,                 src_imm,  0, 32'h1,        32'h0,        32'h100,      32'h0,    32'h101,      0, 0, 32'h0);
        vecs[7]  = mk(and_op,                src_reg2, 0, 32'hFF,       32'h0F,       32'd0,        32'h0,    32'h0F,       0, 0, 32'h0);
        vecs[8]  = mk(sll_op,                src_reg2, 0, 32'd1,        32'd33,       32'd0,        32'h0,    32'd2,        0, 0, 32'h0);
        vecs[9]  = mk(srl_op,                src_reg2, 0, 32'h80000000, 32'd31,       32'd0,        32'h0,    32'd1,        0, 0, 32'h0);
        vecs[10] = mk(add_op,                src_reg2, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,    32'd0,        0, 0, 32'h0);
        vecs[11] = mk(add_op,                src_imm,  0, 32'd5,        32'd100,      32'hFFFFFFFF, 32'h0,    32'd4,        0, 0, 32'h0);
        vecs[12] = mk(alu_op_t'(5'h1F),      src_reg2, 0, 32'd3,        32'd4,        32'd0,        32'h0,    32'd0,        0, 0, 32'h0);
        vecs[13] = mk(eq_op,                 src_reg2, 1, 32'd5,        32'd5,        32'h10,       32'h100,  32'd0,        1, 1, 32'h120);
        vecs[14] = mk(eq_op,                 src_reg2, 1, 32'd5,        32'd6,        32'h10,       32'h100,  32'd0,        1, 0, 32'h104);
        vecs[15] = mk(not_eq_op,             src_reg2, 1, 32'd1,        32'd2,        32'hFFFFFFFE, 32'h200,  32'd0,        1, 1, 32'h1FC);
        vecs[16] = mk(less_than_op,          src_reg2, 1, 32'hFFFFFFFF, 32'd1,        32'd8,        32'h0,    32'd0,        1, 1, 32'h10);
        vecs[17] = mk(ltu_op,                src_reg2, 1, 32'hFFFFFFFF, 32'd1,        32'd8,        32'h300,  32'd0,        1, 0, 32'h304);
        vecs[18] = mk(geu_op,                src_reg2, 1, 32'hFFFFFFFF, 32'd1,        32'd4,        32'h40,   32'd0,        1, 1, 32'h48);
        vecs[19] = mk(greater_equal_than_op, src_reg2, 1, 32'hFFFFFFFB, 32'd3,        32'd4,        32'h50,   32'd0,        1, 0, 32'h54);

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        src1_val = '0; src2_val = '0; immediate = '0; pc_in = '0;
        dst_reg_addr = '0; tag_in = '0; control = '0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_br_valid", 64'(br_valid), 64'd0);
        check("rst_result", 64'(result_val), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single-issue table: output appears LAT cycles after the accept cycle, then clears.
        for (int i = 0; i < NV; i++) begin
            drive(i);
            tick();
            in_valid = 1'b0;
            check($sformatf("v%0d_latency_gap", i), 64'(out_valid | br_valid), 64'd0);
            tick();
            check_out(i, "v");
            tick();
            check($sformatf("v%0d_cleared", i), 64'(out_valid | br_valid), 64'd0);
        end

        // Back-to-back issue of vectors 1..4
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(c + 1);
            else in_valid = 1'b0;
            tick();
            if (c >= 1) check_out(c, "b2b");
        end
        in_valid = 1'b0;
        tick();
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Backpressure: vector 5 then vector 7 with out_ready low
        out_ready = 1'b0;
        drive(5);
        tick();
        check("stall_in_ready_empty", 64'(in_ready), 64'd1);
        drive(7);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
            check_out(5, "stall");
        end
        out_ready = 1'b1;
        tick();
        check_out(7, "drain");
        tick();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Branch at output while out_ready low still pulses once and never stalls
        out_ready = 1'b0;
        drive(13);
        tick();
        in_valid = 1'b0;
        tick();
        check_out(13, "brstall");
        check("brstall_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("brstall_pulse_end", 64'(br_valid), 64'd0);
        out_ready = 1'b1;

        // Flush with in-flight result (stalled), in-flight branch, and a coincident issue
        out_ready = 1'b0;
        drive(0);
        tick();
        drive(13);
        tick();
        drive(1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("flush%0d_out_valid", k), 64'(out_valid), 64'd0);
            check($sformatf("flush%0d_br_valid", k), 64'(br_valid), 64'd0);
            tick();
        end

        // Reset mid-stream, then a fresh issue completes with normal latency
        drive(1);
        tick();
        drive(2);
        tick();
        drive(3);
        reset = 1'b0;
        tick();
        in_valid = 1'b0;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_br_valid", 64'(br_valid), 64'd0);
        check("mrst_result", 64'(result_val), 64'd0);
        check("mrst_addr", 64'(result_addr), 64'd0);
        check("mrst_tag", 64'(tag_out), 64'd0);
        check("mrst_target", 64'(br_target), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        drive(5);
        tick();
        in_valid = 1'b0;
        check("mrst_gap", 64'(out_valid), 64'd0);
        tick();
        check_out(5, "mrst");
        tick();
        check("mrst_done", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
